gpio_timer_ctrl: RTL and testbench
==================================

# gpio_timer_ctrl

Parametrised GPIO and timer peripheral on the processor's simple register bus (addr/wea/din/dout). Provides GPIO_W bidirectional pins with per-pin direction, atomic set/clear, synchronised inputs with rising-edge capture, and a prescaled free-running timer with compare-match interrupt. Drives a single level-sensitive `irq` to the interrupt controller.

## Interface
- `GPIO_W`, 16: number of GPIO pins, 1..32.
- `TIMER_W`, 32: timer/compare width, 8..32.
- `PRESCALE_DEF`, 48000: PRESCALE reset value, clk cycles per timer tick.
- `BASE`, 12'hFFF: value `addr[15:4]` must match to select the block.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `wea` in 1: write strobe, single cycle.
- `addr` in 16: word address; `addr[3:0]` selects the register.
- `din` in 32: write data.
- `dout` out 32: read data, combinational from `addr`; unused bits 0.
- `gpio_o` out GPIO_W: output register.
- `gpio_oe` out GPIO_W: 1 = pin driven (DIR).
- `gpio_i` in GPIO_W: asynchronous pin inputs.
- `irq` out 1: interrupt, level.

## Operation
Register map (`addr[3:0]`); writes take effect only when `wea` and BASE match:
- 0 OUT rw; 1 DIR rw; 2 IN ro (synchronised pins); 3 SET wo, OUT |= din; 4 CLR wo, OUT &= ~din.
- 5 TIMER rw; 6 PRESCALE rw; 7 COMPARE rw.
- 8 STATUS: bit0 MATCH (W1C), bit1 EDGE_ANY ro (= |EDGE_PEND & EDGE_EN); bit31 IRQ_EN rw.
- 9 EDGE_EN rw; 10 EDGE_PEND W1C.
- 11–15: read 0, writes ignored.

Behaviour:
- Reset: OUT, DIR, TIMER, COMPARE, STATUS, EDGE_EN, EDGE_PEND, prescale counter, sync flops all 0. PRESCALE = PRESCALE_DEF. `gpio_o`, `gpio_oe`, `irq` are 0.
- Prescaler: counter `pc` counts 0..PRESCALE-1. At PRESCALE-1, `pc` returns to 0 and a one-cycle tick is issued. PRESCALE = 0 halts the timer (`pc` held at 0, no ticks). A PRESCALE write also clears `pc`.
- Timer: increments by 1 on each tick. Wraps from 2^TIMER_W−1 to 0 with no flag.
- TIMER write in the same cycle as a tick: the write wins and the tick is lost.
- MATCH is set in the cycle the timer takes a value equal to COMPARE via a tick. A software write to TIMER never sets MATCH.
- Inputs: two-flop synchroniser, then a previous-value flop. A rising edge sets EDGE_PEND[i] regardless of EDGE_EN. Falling edges are ignored.
- W1C versus set in the same cycle: set wins (MATCH and EDGE_PEND).
- `irq` = IRQ_EN & (MATCH | EDGE_ANY), registered.
- Bits above GPIO_W and TIMER_W are ignored on write and read as 0.

## Timing
- Register writes are visible on `dout`, `gpio_o` and `gpio_oe` the cycle after the `wea` edge.
- `gpio_i` change → IN updated after 2 clk edges → EDGE_PEND set on the 3rd edge → `irq` high on the 4th edge.
- Tick period is exactly PRESCALE cycles. MATCH is set on the tick edge, and `irq` rises one cycle later.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). Release is synchronous to `clk`.

## Configuration
- `GPIO_TIMER_EDGE_IRQ_EN`: when defined, the edge-detect logic, EDGE_EN, EDGE_PEND and STATUS.bit1 are built.
- When undefined, addresses 9 and 10 read 0, EDGE_ANY = 0, and `irq` depends on MATCH only. The synchroniser and the IN register always remain.

## Structure
- Package `gpio_timer_pkg`: register offset constants (REG_OUT … REG_EDGE_PEND), the STATUS bit positions, and the BASE default.
- Sub-module `gpio_sync_edge`, parameterised by width: contains the synchroniser, the previous-value flop, and the rise-pulse output. It is instantiated once.

## Test plan
- Reset: release `rst` → all outputs 0, PRESCALE reads 48000, TIMER stays 0 for 47999 cycles, then reads 1 at cycle 48000.
- Write OUT=16'h00F0, SET 16'h000F, CLR 16'h0030 → `gpio_o` = 16'h00CF. Write DIR=16'hFFFF → `gpio_oe` all 1.
- PRESCALE=4, COMPARE=3, IRQ_EN=1 → MATCH after 12 cycles and `irq` 1 cycle later. W1C STATUS=1 → `irq` drops. A W1C coinciding with a new match leaves MATCH=1.
- TIMER = 2^TIMER_W−1, PRESCALE=1 → TIMER wraps to 0 after one tick with MATCH clear (COMPARE≠0). A TIMER write on a tick cycle → the written value is held.
- (`GPIO_TIMER_EDGE_IRQ_EN`) EDGE_EN=1, `gpio_i[0]` 0→1 → EDGE_PEND[0]=1 on the 3rd edge and `irq` on the 4th edge. A 1→0 transition sets nothing. W1C clears it.
- Assert `rst` while TIMER=5 and `irq`=1 → TIMER=0 and `irq`=0 without a clock edge.

Source files
------------

// File: rtl/gpio_timer_pkg.sv
// gpio_timer_pkg: shared constants for the GPIO/timer peripheral.
//   Register offsets (addr[3:0]), STATUS bit positions and the default
//   bus base (addr[15:4]).
package gpio_timer_pkg;

  localparam logic [3:0] REG_OUT       = 4'd0;
  localparam logic [3:0] REG_DIR       = 4'd1;
  localparam logic [3:0] REG_IN        = 4'd2;
  localparam logic [3:0] REG_SET       = 4'd3;
  localparam logic [3:0] REG_CLR       = 4'd4;
  localparam logic [3:0] REG_TIMER     = 4'd5;
  localparam logic [3:0] REG_PRESCALE  = 4'd6;
  localparam logic [3:0] REG_COMPARE   = 4'd7;
  localparam logic [3:0] REG_STATUS    = 4'd8;
  localparam logic [3:0] REG_EDGE_EN   = 4'd9;
  localparam logic [3:0] REG_EDGE_PEND = 4'd10;

  localparam int unsigned STATUS_MATCH_BIT  = 0;
  localparam int unsigned STATUS_EDGE_BIT   = 1;
  localparam int unsigned STATUS_IRQEN_BIT  = 31;

  localparam logic [11:0] BASE_DEF = 12'hFFF;

endpackage

// File: rtl/gpio_timer_ctrl_sync_edge.sv
// gpio_sync_edge: two-flop synchroniser for asynchronous pins, followed by a
// previous-value flop used to detect rising edges.
//   clk, rst      : clock, async active-low reset
//   d_i [W]       : asynchronous inputs
//   sync_o [W]    : synchronised inputs (registered)
//   rise_c_o [W]  : one-cycle rising-edge pulse (combinational)
module gpio_sync_edge #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_c_o
);

  logic [W-1:0] meta_q, sync_q, prev_q;

  // Synchroniser chain plus one history stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o   = sync_q;
  assign rise_c_o = sync_q & ~prev_q;

endmodule

// File: rtl/gpio_timer_ctrl.sv
// gpio_timer_ctrl: GPIO + prescaled timer peripheral on the simple register bus.
//   clk, rst (async active-low), wea/addr/din write port, dout combinational
//   read data; gpio_o/gpio_oe pin drive, gpio_i async pin inputs; irq level.
//   Optional feature macro: GPIO_TIMER_EDGE_IRQ_EN builds edge detect,
//   EDGE_EN, EDGE_PEND and STATUS.EDGE_ANY.
module gpio_timer_ctrl
  import gpio_timer_pkg::*;
#(
  parameter int unsigned GPIO_W       = 16,
  parameter int unsigned TIMER_W      = 32,
  parameter int unsigned PRESCALE_DEF = 48000,
  parameter logic [11:0] BASE         = BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wea,
  input  logic [15:0]       addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic              irq
);

  logic              sel, wr;
  logic [3:0]        ra;
  logic              wr_timer, wr_prescale, wr_status;
  logic [GPIO_W-1:0] din_g, in_sync, rise;
  logic [TIMER_W-1:0] din_t, timer_inc;
  logic [GPIO_W-1:0] out_q, out_d, dir_q, dir_d;
  logic [TIMER_W-1:0] timer_q, timer_d, compare_q, compare_d;
  logic [31:0]       prescale_q, prescale_d, pc_q, pc_d;
  logic              match_q, match_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic              tick, match_set, edge_any;

  assign sel         = (addr[15:4] == BASE);
  assign wr          = wea & sel;
  assign ra          = addr[3:0];
  assign wr_timer    = wr && (ra == REG_TIMER);
  assign wr_prescale = wr && (ra == REG_PRESCALE);
  assign wr_status   = wr && (ra == REG_STATUS);
  assign din_g       = din[GPIO_W-1:0];
  assign din_t       = din[TIMER_W-1:0];

  gpio_sync_edge #(.W(GPIO_W)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .d_i      (gpio_i),
    .sync_o   (in_sync),
    .rise_c_o (rise)
  );

  // Prescaler tick: PRESCALE == 0 halts the timer entirely.
  assign tick      = (prescale_q != 32'd0) && (pc_q == prescale_q - 32'd1);
  assign timer_inc = timer_q + TIMER_W'(1);
  // A software TIMER write suppresses the tick, so it can never raise MATCH.
  assign match_set = tick && !wr_timer && (timer_inc == compare_q);

  // Next-state for bus registers, prescaler, timer and status.
  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    compare_d  = compare_q;
    prescale_d = prescale_q;
    irq_en_d   = irq_en_q;
    timer_d    = timer_q;
    pc_d       = pc_q + 32'd1;
    match_d    = match_q;
    if (wr) begin
      case (ra)
        REG_OUT:      out_d      = din_g;
        REG_DIR:      dir_d      = din_g;
        REG_SET:      out_d      = out_q | din_g;
        REG_CLR:      out_d      = out_q & ~din_g;
        REG_COMPARE:  compare_d  = din_t;
        REG_PRESCALE: prescale_d = din;
        REG_STATUS:   irq_en_d   = din[STATUS_IRQEN_BIT];
        default:      ;
      endcase
    end
    if (wr_prescale || (prescale_q == 32'd0) || tick) pc_d = 32'd0;
    if (wr_timer)  timer_d = din_t;
    else if (tick) timer_d = timer_inc;
    // Set beats W1C.
    if (match_set)                              match_d = 1'b1;
    else if (wr_status && din[STATUS_MATCH_BIT]) match_d = 1'b0;
    irq_d = irq_en_q & (match_q | edge_any);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= '0;
      dir_q      <= '0;
      timer_q    <= '0;
      compare_q  <= '0;
      prescale_q <= 32'(PRESCALE_DEF);
      pc_q       <= '0;
      match_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      timer_q    <= timer_d;
      compare_q  <= compare_d;
      prescale_q <= prescale_d;
      pc_q       <= pc_d;
      match_q    <= match_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

`ifdef GPIO_TIMER_EDGE_IRQ_EN
  logic [GPIO_W-1:0] edge_en_q, edge_en_d, edge_pend_q, edge_pend_d;
  logic              wr_edge_en, wr_edge_pend;

  assign wr_edge_en   = wr && (ra == REG_EDGE_EN);
  assign wr_edge_pend = wr && (ra == REG_EDGE_PEND);

  // Rising edges latch regardless of EDGE_EN; a new edge beats W1C.
  always_comb begin
    edge_en_d   = wr_edge_en ? din_g : edge_en_q;
    edge_pend_d = (edge_pend_q & ~(wr_edge_pend ? din_g : '0)) | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_en_q   <= '0;
      edge_pend_q <= '0;
    end else begin
      edge_en_q   <= edge_en_d;
      edge_pend_q <= edge_pend_d;
    end
  end

  assign edge_any = |(edge_pend_q & edge_en_q);
`else
  logic unused_rise;
  assign unused_rise = ^rise;
  assign edge_any    = 1'b0;
`endif

  // Read mux; unselected or unmapped addresses read 0.
  always_comb begin
    dout = '0;
    if (sel) begin
      case (ra)
        REG_OUT:      dout = 32'(out_q);
        REG_DIR:      dout = 32'(dir_q);
        REG_IN:       dout = 32'(in_sync);
        REG_TIMER:    dout = 32'(timer_q);
        REG_PRESCALE: dout = prescale_q;
        REG_COMPARE:  dout = 32'(compare_q);
        REG_STATUS: begin
          dout[STATUS_MATCH_BIT] = match_q;
          dout[STATUS_EDGE_BIT]  = edge_any;
          dout[STATUS_IRQEN_BIT] = irq_en_q;
        end
`ifdef GPIO_TIMER_EDGE_IRQ_EN
        REG_EDGE_EN:   dout = 32'(edge_en_q);
        REG_EDGE_PEND: dout = 32'(edge_pend_q);
`endif
        default:      dout = '0;
      endcase
    end
  end

  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_timer_ctrl.sv
// Testbench for gpio_timer_ctrl: directed + randomized register-bus stimulus
// checked against a behavioural model of the register map and timer.
module tb_gpio_timer_ctrl;
  import gpio_timer_pkg::*;

`ifdef GPIO_TIMER_EDGE_IRQ_EN
  localparam bit EDGE_BUILT = 1'b1;
`else
  localparam bit EDGE_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wea = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic [15:0] gpio_o, gpio_oe;
  logic [15:0] gpio_i = 16'h0;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  gpio_timer_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .wea     (wea),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .gpio_i  (gpio_i),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; consumes exactly one rising edge.
  task automatic wr_raw(input logic [15:0] a, input logic [31:0] d);
    addr = a; din = d; wea = 1'b1;
    @(negedge clk);
    wea = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_raw({BASE_DEF, a}, d);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    addr = {BASE_DEF, a}; wea = 1'b0;
    #1;
    d = dout;
  endtask

  // Halt, load TIMER/COMPARE, clear MATCH, then restart with prescale p.
  // After k edges the timer is start + k/p; MATCH appears at k = m*p and irq
  // one edge later.
  task automatic timer_run(input logic [31:0] start, input int m, input int p);
    logic [31:0] r;
    wr(REG_PRESCALE, 32'd0);
    wr(REG_TIMER, start);
    wr(REG_COMPARE, start + 32'(m));
    wr(REG_STATUS, 32'h8000_0001);
    wr(REG_PRESCALE, 32'(p));
    for (int k = 1; k <= m * p + 1; k++) begin
      @(negedge clk);
      rd(REG_TIMER, r);
      chk("timer_count", r, start + 32'(k / p));
      rd(REG_STATUS, r);
      chk("status_match", r, {1'b1, 29'b0, 1'b0, (k >= m * p)});
      chk("irq_match", 32'(irq), 32'(k > m * p));
    end
  endtask

  logic [31:0] r, d;
  logic [15:0] m_out, m_dir, v, prev_v, m_pend;
  int op;

  initial begin
    // Reset values
    @(negedge clk);
    #1;
    chk("rst_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    rd(REG_PRESCALE, r); chk("rst_prescale", r, 32'd48000);
    rd(REG_STATUS, r);   chk("rst_status", r, 32'h0);
    rd(REG_TIMER, r);    chk("rst_timer", r, 32'h0);
    repeat (47999) @(negedge clk);
    rd(REG_TIMER, r);    chk("timer_47999", r, 32'd0);
    @(negedge clk);
    rd(REG_TIMER, r);    chk("timer_48000", r, 32'd1);

    // GPIO directed
    wr(REG_OUT, 32'h0000_00F0);
    wr(REG_SET, 32'h0000_000F);
    wr(REG_CLR, 32'h0000_0030);
    chk("gpio_o_setclr", 32'(gpio_o), 32'h0000_00CF);
    rd(REG_SET, r); chk("set_reads0", r, 32'h0);
    wr(REG_DIR, 32'hFFFF_FFFF);
    chk("gpio_oe_all", 32'(gpio_oe), 32'h0000_FFFF);
    rd(REG_DIR, r); chk("dir_upper0", r, 32'h0000_FFFF);
    m_out = 16'h00CF;
    m_dir = 16'hFFFF;

    // GPIO randomized, including writes to a foreign base
    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(0, 4);
      d  = $urandom;
      case (op)
        0: begin wr(REG_OUT, d); m_out = d[15:0]; end
        1: begin wr(REG_DIR, d); m_dir = d[15:0]; end
        2: begin wr(REG_SET, d); m_out = m_out | d[15:0]; end
        3: begin wr(REG_CLR, d); m_out = m_out & ~d[15:0]; end
        default: wr_raw({12'h5A5, REG_OUT}, d);
      endcase
      chk("rnd_gpio_o", 32'(gpio_o), 32'(m_out));
      chk("rnd_gpio_oe", 32'(gpio_oe), 32'(m_dir));
      rd(REG_OUT, r); chk("rnd_out_rd", r, {16'h0, m_out});
    end

    // Match: PRESCALE=4, COMPARE=3
    timer_run(32'd0, 3, 4);
    wr(REG_STATUS, 32'h8000_0001);
    rd(REG_STATUS, r); chk("w1c_match", r, 32'h8000_0000);
    chk("irq_lag", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_drop", 32'(irq), 32'h0);

    // W1C coinciding with a new match: set wins
    wr(REG_PRESCALE, 32'd0);
    wr(REG_TIMER, 32'd0);
    wr(REG_COMPARE, 32'd2);
    wr(REG_PRESCALE, 32'd1);
    @(negedge clk);
    wr(REG_STATUS, 32'h8000_0001);
    rd(REG_STATUS, r); chk("w1c_vs_set", r, 32'h8000_0001);

    // Wrap with COMPARE != 0, then TIMER writes on tick cycles
    wr(REG_PRESCALE, 32'd0);
    wr(REG_TIMER, 32'hFFFF_FFFF);
    wr(REG_COMPARE, 32'd5);
    wr(REG_STATUS, 32'h8000_0001);
    wr(REG_PRESCALE, 32'd1);
    @(negedge clk);
    rd(REG_TIMER, r);  chk("wrap_timer", r, 32'h0);
    rd(REG_STATUS, r); chk("wrap_nomatch", r, 32'h8000_0000);
    wr(REG_TIMER, 32'h0000_1234);
    rd(REG_TIMER, r);  chk("twr_wins", r, 32'h0000_1234);
    @(negedge clk);
    rd(REG_TIMER, r);  chk("twr_next", r, 32'h0000_1235);
    wr(REG_TIMER, 32'd5);
    rd(REG_TIMER, r);  chk("twr_eq_cmp", r, 32'd5);
    rd(REG_STATUS, r); chk("twr_nomatch", r, 32'h8000_0000);
    @(negedge clk);
    rd(REG_TIMER, r);  chk("twr_after", r, 32'd6);
    rd(REG_STATUS, r); chk("twr_nomatch2", r, 32'h8000_0000);

    // Randomized timer runs, one forced across the wrap
    timer_run(32'hFFFF_FFFE, 3, 2);
    for (int i = 0; i < 4; i++)
      timer_run($urandom, $urandom_range(1, 4), $urandom_range(1, 5));

    // Input synchroniser and edge capture
    wr(REG_PRESCALE, 32'd0);
    wr(REG_STATUS, 32'h8000_0001);
    wr(REG_EDGE_EN, 32'h1);
    rd(REG_EDGE_EN, r); chk("edge_en_rd", r, EDGE_BUILT ? 32'h1 : 32'h0);
    gpio_i = 16'h0001;
    @(negedge clk);
    rd(REG_IN, r); chk("in_edge1", r, 32'h0);
    @(negedge clk);
    rd(REG_IN, r); chk("in_edge2", r, 32'h1);
    rd(REG_EDGE_PEND, r); chk("pend_edge2", r, 32'h0);
    @(negedge clk);
    rd(REG_EDGE_PEND, r); chk("pend_edge3", r, EDGE_BUILT ? 32'h1 : 32'h0);
    rd(REG_STATUS, r); chk("edge_any", r, EDGE_BUILT ? 32'h8000_0002 : 32'h8000_0000);
    chk("irq_edge3", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_edge4", 32'(irq), 32'(EDGE_BUILT));
    wr(REG_EDGE_PEND, 32'h1);
    rd(REG_EDGE_PEND, r); chk("pend_w1c", r, 32'h0);
    gpio_i = 16'h0000;
    repeat (5) @(negedge clk);
    rd(REG_EDGE_PEND, r); chk("pend_fall", r, 32'h0);
    rd(REG_IN, r); chk("in_fall", r, 32'h0);
    chk("irq_fall", 32'(irq), 32'h0);

    // Random pin patterns: pending bits accumulate rising edges only
    prev_v = 16'h0;
    m_pend = 16'h0;
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom);
      gpio_i = v;
      repeat (3) @(negedge clk);
      m_pend = m_pend | (v & ~prev_v);
      rd(REG_IN, r); chk("rnd_in", r, 32'(v));
      rd(REG_EDGE_PEND, r); chk("rnd_pend", r, EDGE_BUILT ? 32'(m_pend) : 32'h0);
      prev_v = v;
    end
    rd(REG_EDGE_PEND + 4'd1, r); chk("unmapped_rd", r, 32'h0);

    // Async reset with TIMER=5 and irq=1
    wr(REG_EDGE_PEND, 32'hFFFF_FFFF);
    wr(REG_OUT, 32'h0000_A5A5);
    wr(REG_TIMER, 32'd4);
    wr(REG_COMPARE, 32'd5);
    wr(REG_STATUS, 32'h8000_0001);
    wr(REG_PRESCALE, 32'd1);
    wr(REG_PRESCALE, 32'd0);
    @(negedge clk);
    rd(REG_TIMER, r); chk("pre_rst_timer", r, 32'd5);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    rst = 1'b0;
    #1;
    chk("async_irq", 32'(irq), 32'h0);
    chk("async_gpio_o", 32'(gpio_o), 32'h0);
    rd(REG_TIMER, r);  chk("async_timer", r, 32'h0);
    rd(REG_STATUS, r); chk("async_status", r, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
